// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM states
// and the counter-width helper.
package nibble_serial_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Width needed to count 0..v-1; never returns less than 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_csa.sv
// 4-bit carry-select adder slice: low half ripples, high half is
// precomputed for both carries and selected by the low-half carry.
module carry_select_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [2:0] lo;
    logic [2:0] hi0;
    logic [2:0] hi1;

    always_comb begin
        lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
        hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
        hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
        if (lo[2]) begin
            sum  = {hi1[1:0], lo[1:0]};
            cout = hi1[2];
        end else begin
            sum  = {hi0[1:0], lo[1:0]};
            cout = hi0[2];
        end
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder reusing one 4-bit carry_select_adder,
// one nibble per clock, LSB first, behind a start/busy/done handshake.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned CW      = clog2(NIBBLES);
    localparam logic [CW-1:0] LAST  = CW'(NIBBLES - 1);

    state_t             state, state_n;
    logic [CW-1:0]      cnt;
    logic               carry;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [WIDTH-1:0]   acc, acc_n;
    logic [NIBBLE_W-1:0] an, bn, sn;
    logic               nc;
    logic               accept, last_step;

    carry_select_adder u_csa (
        .a    (an),
        .b    (bn),
        .cin  (carry),
        .sum  (sn),
        .cout (nc)
    );

    // Operand nibble select and partial-result merge for the current count.
    always_comb begin
        an    = '0;
        bn    = '0;
        acc_n = acc;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (32'(cnt) == i) begin
                an                     = a_r[i*NIBBLE_W +: NIBBLE_W];
                bn                     = b_r[i*NIBBLE_W +: NIBBLE_W];
                acc_n[i*NIBBLE_W +: NIBBLE_W] = sn;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        last_step = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_RUN;
                    accept  = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt == LAST) begin
                    state_n   = ST_IDLE;
                    last_step = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= last_step;
            if (accept) begin
                a_r   <= a;
                b_r   <= b;
                carry <= cin;
                cnt   <= '0;
                acc   <= '0;
            end else if (state == ST_RUN) begin
                acc   <= acc_n;
                carry <= nc;
                if (last_step) begin
                    cnt  <= '0;
                    sum  <= acc_n;
                    cout <= nc;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks of nibble_serial_adder (WIDTH=16) against
// a plain-arithmetic reference of a + b + cin.
module tb_nibble_serial_adder;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done;
    logic [W-1:0] sum;
    logic         cout;

    int total;
    int bad;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for done, counting edges; busy must stay high until then.
    task automatic wait_done(input string tag, output int n);
        int notbusy;
        n = 0;
        notbusy = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
            if (done !== 1'b1 && busy !== 1'b1) notbusy++;
        end
        check({tag, ":busy_during_run"}, notbusy, 0);
        check({tag, ":done_seen"}, done, 1);
        check({tag, ":busy_at_done"}, busy, 0);
    endtask

    // Starts an op from the current cycle (idle or done cycle) and checks the result.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c);
        logic [W:0] e;
        int n;
        e = model(x, y, c);
        a = x; b = y; cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        check({tag, ":busy_after_accept"}, busy, 1);
        wait_done(tag, n);
        check({tag, ":latency"}, n, 4);
        check({tag, ":sum"}, sum, e[W-1:0]);
        check({tag, ":cout"}, cout, e[W]);
    endtask

    initial begin
        int n;
        logic [W-1:0] hold;
        int seen;
        total = 0;
        bad   = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset:busy", busy, 0);
        check("reset:done", done, 0);
        check("reset:sum", sum, 0);
        check("reset:cout", cout, 0);
        tick();

        run_op("basic", 16'h1234, 16'h4321, 1'b0);
        check("basic:sum_const", sum, 16'h5555);
        tick();
        check("basic:done_pulse_one_cycle", done, 0);
        check("basic:sum_hold", sum, 16'h5555);

        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0);
        check("ripple:sum_const", sum, 16'h0000);
        check("ripple:cout_const", cout, 1);
        // start presented in the done cycle must be accepted immediately
        run_op("b2b", 16'h8000, 16'h8000, 1'b0);
        check("b2b:cout_const", cout, 1);
        tick();

        run_op("cin1", 16'h9696, 16'h6969, 1'b1);
        check("cin1:sum_const", sum, 16'h0000);
        tick();
        run_op("cin0", 16'h9696, 16'h6969, 1'b0);
        check("cin0:sum_const", sum, 16'hFFFF);
        tick();

        // start while busy is ignored; operands changed mid-flight
        a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 16'hAAAA; b = 16'h5555; start = 1'b1;
        tick();
        start = 1'b0; a = 16'h7777; b = 16'h3333; cin = 1'b1;
        wait_done("busy_start", n);
        check("busy_start:latency", n, 1);
        check("busy_start:sum", sum, 16'h0002);
        check("busy_start:cout", cout, 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("busy_start:no_second_op", seen, 0);
        check("busy_start:sum_hold", sum, 16'h0002);

        // reset after two RUN edges aborts the op
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst:busy", busy, 0);
        check("midrst:done", done, 0);
        check("midrst:sum", sum, 0);
        check("midrst:cout", cout, 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1) seen++;
        end
        check("midrst:no_done", seen, 0);
        run_op("after_rst", 16'h1111, 16'h2222, 1'b0);
        check("after_rst:sum_const", sum, 16'h3333);
        tick();

        // reset and start on the same edge: reset wins
        a = 16'h0F0F; b = 16'h0101; start = 1'b1; rst = 1'b1;
        tick();
        start = 1'b0; rst = 1'b0;
        check("rst_start:busy", busy, 0);
        check("rst_start:sum", sum, 0);

        for (int k = 0; k < 25; k++) begin
            run_op("random", W'($urandom), W'($urandom), 1'($urandom));
            hold = sum;
            if ($urandom_range(0, 1) == 1) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) tick();
                check("random:hold", sum, hold);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder built around the team's existing 4-bit carry_select_adder.
- Adds two WIDTH-bit operands plus carry-in one nibble per clock, LSB nibble first.
- Handles operand capture, nibble sequencing, carry chaining between cycles and result assembly behind a start/busy/done handshake.
- Targets area-constrained datapaths where one 4-bit adder is reused instead of a full-width adder.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, derived count of nibble cycles per operation; not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A; sampled with an accepted start
- b  input  WIDTH  operand B; sampled with an accepted start
- cin  input  1  carry-in; sampled with an accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when sum/cout are valid for a new result
- sum  output  WIDTH  registered result
- cout  output  1  registered final carry-out

Behaviour:
- Reset values: busy=0, done=0, sum=0, cout=0, state=IDLE, nibble counter=0, internal carry=0, operand registers=0.
- FSM states:
  - IDLE: waits for start.
  - RUN: performs nibble additions.
- IDLE to RUN:
  - Taken at the edge where start=1 and busy=0.
  - Same edge: a, b and cin are captured into internal registers, the counter clears to 0, and busy rises.
- Each RUN edge:
  - Nibble i = counter of the captured a and b goes to the carry_select_adder, together with the carry register.
  - The adder's sum nibble is written into result bits [4i+3:4i].
  - The carry register takes the adder's cout, and the counter increments.
- RUN to IDLE:
  - Taken on the edge that processes nibble NIBBLES-1.
  - Same edge: sum takes the fully assembled result, cout takes the final carry, done=1 for exactly one cycle, and busy=0.
- Latency: start accepted at edge k gives done high in the cycle after edge k+NIBBLES (4 RUN edges for WIDTH=16).
  - Throughput is one operation per NIBBLES+1 edges. Back-to-back operation is possible because start is accepted in the cycle done is high.
- Output hold:
  - sum and cout are updated only at completion and hold their value otherwise, including during the next operation.
  - Partial results go to an internal register, never to sum.
- start while busy=1: ignored. No queuing, and operands/cin are not re-sampled.
- Operand changes after acceptance have no effect on the operation in flight.
- Width rule: the result is exactly (a + b + cin) mod 2^WIDTH, and cout is bit WIDTH of the true sum.
- Reset mid-operation: aborts immediately. All registers return to reset values, and no done pulse is produced.
- rst together with start: rst wins; the start is not accepted.
- done and busy are never both high.

Decomposition:
- Shared package holds:
  - NIBBLE_W = 4.
  - State encoding constants: ST_IDLE = 1'b0, ST_RUN = 1'b1.
  - Counter width function clog2(NIBBLES).
- One sub-module: the existing carry_select_adder (a[3:0], b[3:0], cin, sum[3:0], cout), instantiated once as a purely combinational slice.
  - All sequencing, muxing and registers live in nibble_serial_adder.

Test Plan (WIDTH=16):
- Basic add: reset 2 cycles, then start with a=16'h1234, b=16'h4321, cin=0. Required: busy high for 4 cycles, then done pulse with sum=16'h5555, cout=0.
- Full carry ripple across nibbles: a=16'hFFFF, b=16'h0001, cin=0. Required: sum=16'h0000, cout=1, done exactly 4 edges after acceptance.
- Carry-in propagation: a=16'h9696, b=16'h6969, cin=1. Required: sum=16'h0000, cout=1. Repeat with cin=0: required sum=16'hFFFF, cout=0.
- Start while busy: start 16'h0001+16'h0001. Two cycles later pulse start with a=16'hAAAA, b=16'h5555 and change a/b. Required: single done with sum=16'h0002, cout=0; second start ignored; sum holds afterwards.
- Back-to-back: assert start with 16'h8000+16'h8000 in the done cycle of the prior op. Required: accepted immediately; next done 4 edges later with sum=16'h0000, cout=1.
- Reset mid-operation: assert rst after 2 RUN edges of 16'h1111+16'h2222. Required: next cycle busy=0, done=0, sum=0, cout=0. No done pulse follows; a fresh start then completes normally with sum=16'h3333.
